// File: rtl/exhaustive_response_capture.sv
// -----------------------------------------------------------------------------
// exhaustive_response_capture
//
// Purpose:
//   Sweeps a small DUT through every input pattern 0 .. 2**WIDTH-1 in
//   ascending order. Each pattern is held for SETTLE_CYCLES cycles, then the
//   DUT's single response bit is sampled for one cycle. The full response
//   truth table is built on chip and compared bit-for-bit against a golden
//   table, giving a pass/fail result together with the captured table.
//
// Parameters:
//   WIDTH          number of DUT input bits (2**WIDTH patterns)
//   SETTLE_CYCLES  cycles each pattern is held before sampling (0..15)
//
// Ports:
//   CK              in   system clock, rising edge
//   reset           in   asynchronous active-low reset
//   start           in   single-cycle sweep request (ignored while busy)
//   N_out           out  pattern to the DUT, bit-reversed (N_out[0] = index MSB)
//   dut_out         in   DUT response bit, sampled only in SAMPLE
//   golden_vec      in   expected response, bit p for pattern p
//   busy            out  sweep in progress
//   done            out  sweep complete, held until next start or reset
//   resp_vec        out  captured response, bit p for pattern p
//   ones_count      out  number of 1s in resp_vec
//   mismatch        out  any captured bit differed from golden_vec
//   mismatch_count  out  number of differing bits
//   first_mismatch  out  lowest mismatching pattern index, 0 if none
// -----------------------------------------------------------------------------
module exhaustive_response_capture #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  output logic [WIDTH-1:0]      N_out,
  input  logic                  dut_out,
  input  logic [2**WIDTH-1:0]   golden_vec,
  output logic                  busy,
  output logic                  done,
  output logic [2**WIDTH-1:0]   resp_vec,
  output logic [WIDTH:0]        ones_count,
  output logic                  mismatch,
  output logic [WIDTH:0]        mismatch_count,
  output logic [WIDTH-1:0]      first_mismatch
);

  localparam int              NPAT        = 2**WIDTH;
  localparam logic [WIDTH-1:0] P_LAST     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] P_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic            NO_SETTLE   = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    p_q, p_d;
  logic [3:0]          settle_q, settle_d;
  logic [WIDTH-1:0]    n_out_q, n_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NPAT-1:0]     resp_q, resp_d;
  logic [WIDTH:0]      ones_q, ones_d;
  logic                mm_q, mm_d;
  logic [WIDTH:0]      mcnt_q, mcnt_d;
  logic [WIDTH-1:0]    first_q, first_d;

  logic                bit_mismatch_s;
  logic [WIDTH-1:0]    p_inc_s;

  // The pattern index is presented to the DUT MSB-first on N_out[0].
  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      r[WIDTH-1-i] = v[i];
    end
    return r;
  endfunction

  assign bit_mismatch_s = dut_out ^ golden_vec[p_q];
  assign p_inc_s        = p_q + P_ONE;

  // Next-state and result-update logic for the sweep FSM.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    settle_d = settle_q;
    n_out_d  = n_out_q;
    busy_d   = busy_q;
    done_d   = done_q;
    resp_d   = resp_q;
    ones_d   = ones_q;
    mm_d     = mm_q;
    mcnt_d   = mcnt_q;
    first_d  = first_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          p_d      = {WIDTH{1'b0}};
          settle_d = 4'd0;
          n_out_d  = {WIDTH{1'b0}};
          busy_d   = 1'b1;
          done_d   = 1'b0;
          resp_d   = {NPAT{1'b0}};
          ones_d   = {(WIDTH+1){1'b0}};
          mm_d     = 1'b0;
          mcnt_d   = {(WIDTH+1){1'b0}};
          first_d  = {WIDTH{1'b0}};
          state_d  = NO_SETTLE ? SAMPLE : SETTLE;
        end else begin
          state_d = state_q;
        end
      end

      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      SAMPLE: begin
        resp_d[p_q] = dut_out;
        ones_d      = ones_q + {{WIDTH{1'b0}}, dut_out};
        if (bit_mismatch_s) begin
          mm_d   = 1'b1;
          mcnt_d = mcnt_q + {{WIDTH{1'b0}}, 1'b1};
          // mm_q still low means no earlier pattern has mismatched.
          if (!mm_q) begin
            first_d = p_q;
          end else begin
            first_d = first_q;
          end
        end else begin
          mm_d = mm_q;
        end

        if (p_q != P_LAST) begin
          p_d     = p_inc_s;
          n_out_d = bit_reverse(p_inc_s);
          state_d = NO_SETTLE ? SAMPLE : SETTLE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          n_out_d = {WIDTH{1'b0}};
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers, cleared asynchronously by reset.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      p_q      <= {WIDTH{1'b0}};
      settle_q <= 4'd0;
      n_out_q  <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resp_q   <= {NPAT{1'b0}};
      ones_q   <= {(WIDTH+1){1'b0}};
      mm_q     <= 1'b0;
      mcnt_q   <= {(WIDTH+1){1'b0}};
      first_q  <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      settle_q <= settle_d;
      n_out_q  <= n_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      resp_q   <= resp_d;
      ones_q   <= ones_d;
      mm_q     <= mm_d;
      mcnt_q   <= mcnt_d;
      first_q  <= first_d;
    end
  end

  assign N_out          = n_out_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign resp_vec       = resp_q;
  assign ones_count     = ones_q;
  assign mismatch       = mm_q;
  assign mismatch_count = mcnt_q;
  assign first_mismatch = first_q;

endmodule

// File: tb/tb_exhaustive_response_capture.sv
// -----------------------------------------------------------------------------
// Testbench for exhaustive_response_capture.
// Two instances: A with SETTLE_CYCLES=1 (default), B with SETTLE_CYCLES=0.
// Each DUT-under-analysis is modelled by a small function selected by mode.
// -----------------------------------------------------------------------------
module tb_exhaustive_response_capture;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic        reset;
  logic        start_a, start_b;
  logic [3:0]  n_out_a, n_out_b;
  logic        dut_out_a, dut_out_b;
  logic [15:0] golden_a, golden_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] resp_a, resp_b;
  logic [4:0]  ones_a, ones_b, mcnt_a, mcnt_b;
  logic        mm_a, mm_b;
  logic [3:0]  first_a, first_b;
  int          mode_a, mode_b;

  exhaustive_response_capture #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut_a (
    .CK(CK), .reset(reset), .start(start_a), .N_out(n_out_a),
    .dut_out(dut_out_a), .golden_vec(golden_a), .busy(busy_a), .done(done_a),
    .resp_vec(resp_a), .ones_count(ones_a), .mismatch(mm_a),
    .mismatch_count(mcnt_a), .first_mismatch(first_a)
  );

  exhaustive_response_capture #(.WIDTH(4), .SETTLE_CYCLES(0)) u_dut_b (
    .CK(CK), .reset(reset), .start(start_b), .N_out(n_out_b),
    .dut_out(dut_out_b), .golden_vec(golden_b), .busy(busy_b), .done(done_b),
    .resp_vec(resp_b), .ones_count(ones_b), .mismatch(mm_b),
    .mismatch_count(mcnt_b), .first_mismatch(first_b)
  );

  // Small combinational DUTs under analysis.
  function automatic logic model_dut(input int mode, input logic [3:0] n);
    case (mode)
      0:       return n[3];
      1:       return &n;
      2:       return 1'b0;
      3:       return 1'b1;
      4:       return n[0];
      default: return 1'b0;
    endcase
  endfunction

  always_comb dut_out_a = model_dut(mode_a, n_out_a);
  always_comb dut_out_b = model_dut(mode_b, n_out_b);

  // Mux of the instance currently under test.
  logic        sel_b;
  logic        m_busy, m_done, m_mm;
  logic [3:0]  m_nout, m_first;
  logic [15:0] m_resp;
  logic [4:0]  m_ones, m_mcnt;
  always_comb begin
    m_busy  = sel_b ? busy_b  : busy_a;
    m_done  = sel_b ? done_b  : done_a;
    m_mm    = sel_b ? mm_b    : mm_a;
    m_nout  = sel_b ? n_out_b : n_out_a;
    m_first = sel_b ? first_b : first_a;
    m_resp  = sel_b ? resp_b  : resp_a;
    m_ones  = sel_b ? ones_b  : ones_a;
    m_mcnt  = sel_b ? mcnt_b  : mcnt_a;
  end

  typedef struct {
    logic [15:0] resp;
    logic [4:0]  ones;
    logic        mm;
    logic [4:0]  mcnt;
    logic [3:0]  first;
    int          cycles;
  } exp_t;

  typedef struct {
    logic        use_b;
    int          mode;
    logic [15:0] golden;
    exp_t        exp;
  } vec_t;

  vec_t vecs [7];
  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},  32'(m_busy),  32'd0);
    check({tag, "_done"},  32'(m_done),  32'd0);
    check({tag, "_nout"},  32'(m_nout),  32'd0);
    check({tag, "_resp"},  32'(m_resp),  32'd0);
    check({tag, "_ones"},  32'(m_ones),  32'd0);
    check({tag, "_mm"},    32'(m_mm),    32'd0);
    check({tag, "_mcnt"},  32'(m_mcnt),  32'd0);
    check({tag, "_first"}, 32'(m_first), 32'd0);
  endtask

  task automatic run_sweep(input vec_t v);
    exp_t       e;
    int         n;
    logic [3:0] k;
    sel_b = v.use_b;
    if (v.use_b) begin
      mode_b = v.mode; golden_b = v.golden;
    end else begin
      mode_a = v.mode; golden_a = v.golden;
    end
    sb.push_back(v.exp);
    @(posedge CK); #1;
    if (v.use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge CK); #1;   // E0
    start_a = 1'b0; start_b = 1'b0;
    check("start_busy", 32'(m_busy), 32'd1);
    check("start_done", 32'(m_done), 32'd0);
    check("start_resp", 32'(m_resp), 32'd0);
    check("start_mm",   32'(m_mm),   32'd0);
    check("start_ones", 32'(m_ones), 32'd0);
    check("start_nout", 32'(m_nout), 32'd0);
    n = 0;
    while (!m_done && n < 200) begin
      @(posedge CK); #1;
      n++;
      if (v.use_b && n < 16) begin
        k = n[3:0];
        check("nout_step", 32'(m_nout), 32'({k[0], k[1], k[2], k[3]}));
      end
    end
    e = sb.pop_front();
    check("done_latency", 32'(n),       32'(e.cycles));
    check("resp_vec",     32'(m_resp),  32'(e.resp));
    check("ones_count",   32'(m_ones),  32'(e.ones));
    check("mismatch",     32'(m_mm),    32'(e.mm));
    check("mm_count",     32'(m_mcnt),  32'(e.mcnt));
    check("first_mm",     32'(m_first), 32'(e.first));
    check("end_busy",     32'(m_busy),  32'd0);
    check("end_nout",     32'(m_nout),  32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 0, 16'hAAAA, '{16'hAAAA, 5'd8,  1'b0, 5'd0,  4'd0, 32}};
    vecs[1] = '{1'b0, 1, 16'h8020, '{16'h8000, 5'd1,  1'b1, 5'd1,  4'd5, 32}};
    vecs[2] = '{1'b0, 0, 16'hAAAA, '{16'hAAAA, 5'd8,  1'b0, 5'd0,  4'd0, 32}};
    vecs[3] = '{1'b0, 4, 16'hFF00, '{16'hFF00, 5'd8,  1'b0, 5'd0,  4'd0, 32}};
    vecs[4] = '{1'b0, 3, 16'h0F0F, '{16'hFFFF, 5'd16, 1'b1, 5'd8,  4'd4, 32}};
    vecs[5] = '{1'b1, 2, 16'hFFFF, '{16'h0000, 5'd0,  1'b1, 5'd16, 4'd0, 16}};
    vecs[6] = '{1'b1, 0, 16'hAAAA, '{16'hAAAA, 5'd8,  1'b0, 5'd0,  4'd0, 16}};

    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    golden_a = 16'h0; golden_b = 16'h0; mode_a = 2; mode_b = 2; sel_b = 1'b0;
    repeat (3) @(posedge CK);
    #1 reset = 1'b1;

    // Idle after reset with no start.
    repeat (50) @(posedge CK);
    #1;
    sel_b = 1'b0; #0 check_cleared("idle_a");
    sel_b = 1'b1; #0 check_cleared("idle_b");

    for (int i = 0; i < 7; i++) begin
      run_sweep(vecs[i]);
    end

    // Start re-pulsed mid-sweep is ignored; reset mid-sweep clears everything.
    sel_b = 1'b0; mode_a = 0; golden_a = 16'hAAAA;
    @(posedge CK); #1 start_a = 1'b1;
    @(posedge CK); #1 start_a = 1'b0;   // E0
    for (int k = 1; k <= 20; k++) begin
      @(posedge CK); #1;
      if (k == 9)  start_a = 1'b1;
      if (k == 10) start_a = 1'b0;
    end
    check("restart_ignored_nout", 32'(n_out_a), 32'(4'b0101));
    check("restart_ignored_busy", 32'(busy_a),  32'd1);
    #2 reset = 1'b0;
    #1 check_cleared("async_reset");
    @(posedge CK); @(posedge CK);
    #1 reset = 1'b1;
    repeat (3) @(posedge CK);
    #1 check_cleared("post_reset_idle");
    run_sweep(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exhaustive_response_capture.md
Name: exhaustive_response_capture

Overview:
- Synthesizable stimulus and response stage that wraps a small combinational or sequential DUT under trojan analysis.
- Upstream side: drives the DUT's N inputs through every pattern 0 .. 2**WIDTH-1 in ascending order.
- Downstream side: samples the DUT's single-bit output once per pattern, builds the full response truth table and compares it bit-for-bit against a golden table.
- Replaces the file-dump sweep with an on-chip pass/fail result plus the captured table.

Parameters:
- WIDTH, 4, number of DUT input bits; 2**WIDTH patterns are applied.
- SETTLE_CYCLES, 1, cycles each pattern is held before sampling; legal range 0..15.

Ports:
- CK  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  single-cycle request to begin a sweep.
- N_out  output  WIDTH  pattern driven to the DUT. N_out[0] is the MSB of the pattern index, so index 4'b0001 drives N_out[3]=1.
- dut_out  input  1  DUT response bit.
- golden_vec  input  2**WIDTH  expected response; bit p is the expected value for pattern p. Must be stable while busy.
- busy  output  1  high while a sweep is in progress.
- done  output  1  level; high from sweep completion until the next accepted start or reset.
- resp_vec  output  2**WIDTH  captured response; bit p is dut_out sampled for pattern p.
- ones_count  output  WIDTH+1  number of 1s captured in resp_vec.
- mismatch  output  1  high if any captured bit differs from golden_vec.
- mismatch_count  output  WIDTH+1  number of differing bits.
- first_mismatch  output  WIDTH  lowest pattern index that mismatched; 0 if none.

Behaviour:
- Reset values (reset=0): all outputs 0; state IDLE; internal pattern counter p=0; settle counter=0.
- States:
  - IDLE: start=1 moves to SETTLE. On that edge (E0): N_out=0, p=0, and resp_vec, ones_count, mismatch, mismatch_count, first_mismatch and done are cleared; busy=1.
  - SETTLE: hold N_out=p for SETTLE_CYCLES edges, then go to SAMPLE. With SETTLE_CYCLES=0, SETTLE is skipped and SAMPLE follows directly.
  - SAMPLE: one cycle. On its closing edge:
    - resp_vec[p] <= dut_out; ones_count += dut_out.
    - If dut_out != golden_vec[p]: mismatch_count += 1, mismatch <= 1, and first_mismatch <= p if this is the first mismatch.
    - If p < 2**WIDTH-1: p += 1, N_out <= p+1, go to SETTLE.
    - Otherwise go to DONE: busy <= 0, done <= 1, N_out <= 0.
  - DONE: results held stable. start=1 behaves exactly as start in IDLE (restart, results cleared).
- Timing:
  - Pattern p is sampled at edge E0 + (p+1)*(SETTLE_CYCLES+1).
  - done rises at E0 + 2**WIDTH*(SETTLE_CYCLES+1). With default parameters that is E0+32.
- start while busy=1 is ignored; the sweep is not restarted or perturbed.
- Counters cannot overflow: the maximum value is 2**WIDTH, which fits in WIDTH+1 bits.
- Reset asserted mid-sweep: everything returns to reset values asynchronously, with no partial results retained. After release the block waits in IDLE for start.
- dut_out is sampled only in SAMPLE; its value in other cycles has no effect.
- golden_vec is read only at SAMPLE edges.

Test Plan:
- Reset released, no start for 50 cycles -> busy=0, done=0, N_out=0, all results 0.
- Default parameters, dut_out tied to N_out[3], golden_vec=16'hAAAA, start pulse -> done at E0+32, resp_vec=16'hAAAA, ones_count=8, mismatch=0, mismatch_count=0.
- dut_out = AND of all N_out bits, golden_vec=16'h8000 except bit 5 flipped (16'h8020) -> resp_vec=16'h8000, ones_count=1, mismatch=1, mismatch_count=1, first_mismatch=5.
- SETTLE_CYCLES=0, dut_out=0, golden_vec=16'hFFFF -> done at E0+16, mismatch_count=16, first_mismatch=0; N_out steps 0..15 on consecutive cycles.
- start re-pulsed at E0+10 and reset pulsed low at E0+20 -> restart ignored; at reset all outputs 0 and busy=0. A new start completes a clean sweep matching the second scenario.
- start pulsed while done=1 after a failing sweep -> done, mismatch and resp_vec cleared on the start edge; the new sweep completes with fresh results.
